rx_fifo_ctrl: RTL and testbench
===============================

# rx_fifo_ctrl

Sequencing controller for the UART receive FIFO. It sits between the UART receiver and the FIFO and turns the receiver's byte-valid pulses and the host's read requests into clean, single-cycle `Data_Rdy` / `Pop_Data` strobes. It arbitrates between write and read traffic, holds one in-flight received byte in a skid register, keeps its own occupancy count, and delivers popped bytes to the host with a request/acknowledge handshake.

## Interface
- `DATA_BITS`, 8, byte width.
- `FIFO_WIDTH`, 4, log2 of FIFO entry count. `ENTRIES = 2**FIFO_WIDTH`.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `Rx_Valid`  in  1  one-cycle pulse: `Rx_Data` holds a received byte.
- `Rx_Data`  in  DATA_BITS  received byte.
- `Host_Rd_Req`  in  1  level: host wants one byte.
- `BIST_Mode`  in  1  suspends FIFO traffic.
- `Fifo_Data_Out`  in  DATA_BITS  FIFO read data.
- `Fifo_Empty`  in  1  FIFO empty flag.
- `Fifo_Rst`  out  1  FIFO reset (active-high).
- `Fifo_Wr_Data`  out  DATA_BITS  FIFO write data.
- `Fifo_Data_Rdy`  out  1  FIFO write strobe.
- `Fifo_Pop_Data`  out  1  FIFO pop strobe.
- `Host_Rd_Ack`  out  1  one-cycle pulse: `Host_Rd_Data` is valid.
- `Host_Rd_Data`  out  DATA_BITS  popped byte; held until the next ack.
- `Occupancy`  out  FIFO_WIDTH+1  entries in the FIFO, 0..ENTRIES.
- `Rx_Drop`  out  1  one-cycle pulse: a received byte was discarded.
- `Drop_Count`  out  8  number of dropped bytes; saturates at 255.
- `Sync_Err`  out  1  sticky: `Fifo_Empty` disagrees with `Occupancy==0` while IDLE.

## Operation
**State machine:** states are IDLE, WRITE, POP, CAPTURE, ACK.
- WRITE asserts `Fifo_Data_Rdy`.
- POP asserts `Fifo_Pop_Data`.
- Every non-IDLE state lasts exactly one cycle and returns through IDLE. Strobes are therefore always single-cycle and separated by at least one low cycle, which the level-sensitive FIFO requires.
- Transitions: WRITE→IDLE; POP→CAPTURE→ACK→IDLE.

**Skid register** (one entry plus a valid bit):
- `Rx_Valid` loads `Rx_Data` when the skid is empty.
- `Rx_Valid` also loads during the WRITE cycle; the old contents are consumed in that same cycle.
- Otherwise the byte is dropped: `Rx_Drop` pulses and `Drop_Count` increments.

**IDLE arbitration, in priority order:**
1. `BIST_Mode=1`: stay in IDLE and issue no strobes. The skid still accepts one byte.
2. Skid valid, `Occupancy<ENTRIES`, and the last grant was not WRITE (or no read is eligible): go to WRITE.
3. `Host_Rd_Req=1` and `Occupancy>0`: go to POP.
4. Skid valid and `Occupancy==ENTRIES` with no eligible read: discard the skid, pulse `Rx_Drop`, and increment `Drop_Count`.
- Fairness rule: after a WRITE, an eligible read wins the next grant.

**Data path and counters:**
- `Fifo_Wr_Data` = skid data.
- `Occupancy` +1 at the end of WRITE and −1 at the end of POP. It never wraps.
- CAPTURE registers `Fifo_Data_Out` into `Host_Rd_Data`.
- ACK pulses `Host_Rd_Ack`.
- `Host_Rd_Req` is sampled only in IDLE. The host must deassert it in the cycle after the ack, or another read is granted.
- A request with `Occupancy==0` waits without acknowledgement until a write completes.

**Consistency check:** in IDLE, `Sync_Err` sets if `Fifo_Empty != (Occupancy==0)`. It is cleared only by reset.

**BIST entry mid-transaction:** the current transaction (including ACK) completes, then the block holds in IDLE.

## Timing
**Reset (`rst` low, asynchronous):**
- State goes to IDLE. Skid is emptied.
- `Occupancy`=0, `Drop_Count`=0, `Sync_Err`=0.
- `Fifo_Data_Rdy`, `Fifo_Pop_Data`, `Host_Rd_Ack` and `Rx_Drop` are 0.
- `Host_Rd_Data` and `Fifo_Wr_Data` are 0.
- `Fifo_Rst`=1.

**Reset release:** `Fifo_Rst` deasserts at the first rising edge after `rst` goes high. No strobe is issued in that cycle.

**Reset mid-transaction:** the transaction is abandoned with no ack, and the FIFO is reset along with the controller.

**Write latency:** `Rx_Valid` in cycle N with IDLE and the skid empty gives `Fifo_Data_Rdy` in cycle N+1. `Occupancy` updates at the end of N+1.

**Read latency:** `Host_Rd_Req` sampled in IDLE in cycle N gives:
- `Fifo_Pop_Data` in N+1,
- capture in N+2,
- `Host_Rd_Ack` and valid data in N+3.

**Throughput:** the minimum spacing between consecutive FIFO strobes is 2 cycles.

**Outputs:** all outputs are registered; none is combinational from an input.

## Test plan
- **Reset, single write:** reset, then `Rx_Valid` with 0xA5 → `Fifo_Data_Rdy`=1 for one cycle, 1 cycle later, with `Fifo_Wr_Data`=0xA5; `Occupancy`=1.
- **Write then read:** write 0x11, 0x22, then hold `Host_Rd_Req` → ack 3 cycles after the sample with `Host_Rd_Data`=0x11; the next ack carries 0x22; `Occupancy` returns to 0.
- **Full FIFO:** 16 writes (`FIFO_WIDTH`=4) fill the FIFO, then a 17th `Rx_Valid` with no read pending → skid discarded, `Rx_Drop` pulses, `Drop_Count`=1, `Occupancy` stays 16.
- **Simultaneous traffic:** `Rx_Valid` and `Host_Rd_Req` in the same cycle with `Occupancy`=3 → WRITE first, then POP (fairness); a second `Rx_Valid` during POP is held in the skid and written after ACK; no drops.
- **BIST and read on empty:** `BIST_Mode`=1 with two `Rx_Valid` pulses → no strobes, the first byte is held, the second is dropped (`Drop_Count`=1); `BIST_Mode`=0 → the held byte is written. A read request with `Occupancy`=0 gets no ack until a write lands.
- **Reset mid-read:** `rst` low during CAPTURE → no ack, all outputs at reset values, `Fifo_Rst` high and released on the first edge after `rst` rises.

Source files
------------

// File: rtl/rx_fifo_ctrl_if.sv
// Signal bundle between the UART receive FIFO controller and its neighbours:
// the UART receiver, the host read port and the FIFO itself.
interface rx_fifo_ctrl_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_WIDTH = 4
);

  // Receiver side
  logic                  Rx_Valid;
  logic [DATA_BITS-1:0]  Rx_Data;
  // Host side
  logic                  Host_Rd_Req;
  logic                  Host_Rd_Ack;
  logic [DATA_BITS-1:0]  Host_Rd_Data;
  logic                  BIST_Mode;
  // FIFO side
  logic [DATA_BITS-1:0]  Fifo_Data_Out;
  logic                  Fifo_Empty;
  logic                  Fifo_Rst;
  logic [DATA_BITS-1:0]  Fifo_Wr_Data;
  logic                  Fifo_Data_Rdy;
  logic                  Fifo_Pop_Data;
  // Status
  logic [FIFO_WIDTH:0]   Occupancy;
  logic                  Rx_Drop;
  logic [7:0]            Drop_Count;
  logic                  Sync_Err;

  // Controller view
  modport master (
    input  Rx_Valid, Rx_Data, Host_Rd_Req, BIST_Mode, Fifo_Data_Out, Fifo_Empty,
    output Fifo_Rst, Fifo_Wr_Data, Fifo_Data_Rdy, Fifo_Pop_Data, Host_Rd_Ack,
           Host_Rd_Data, Occupancy, Rx_Drop, Drop_Count, Sync_Err
  );

  // Environment view (receiver, host and FIFO)
  modport slave (
    output Rx_Valid, Rx_Data, Host_Rd_Req, BIST_Mode, Fifo_Data_Out, Fifo_Empty,
    input  Fifo_Rst, Fifo_Wr_Data, Fifo_Data_Rdy, Fifo_Pop_Data, Host_Rd_Ack,
           Host_Rd_Data, Occupancy, Rx_Drop, Drop_Count, Sync_Err
  );

endinterface

// File: rtl/rx_fifo_ctrl.sv
// UART receive FIFO sequencer: turns receiver byte pulses and host read
// requests into single-cycle FIFO write/pop strobes, with a one-entry skid
// register, its own occupancy count and a request/ack host read port.
module rx_fifo_ctrl #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_WIDTH = 4
) (
  input logic            clk,
  input logic            rst,
  rx_fifo_ctrl_if.master bus
);

  localparam int unsigned Entries = 2 ** FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0] OccFull = (FIFO_WIDTH + 1)'(Entries);
  localparam logic [FIFO_WIDTH:0] OccOne  = (FIFO_WIDTH + 1)'(1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWrite   = 3'd1;
  localparam logic [2:0] StPop     = 3'd2;
  localparam logic [2:0] StCapture = 3'd3;
  localparam logic [2:0] StAck     = 3'd4;

  logic [2:0]           state_q, state_d;
  logic                 skid_vld_q, skid_vld_d;
  logic [DATA_BITS-1:0] skid_data_q, skid_data_d;
  logic [FIFO_WIDTH:0]  occ_q, occ_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;
  logic                 drop_q, drop_d;
  logic                 sync_err_q, sync_err_d;
  logic                 fifo_rst_q;
  logic                 last_wr_q;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic                 data_rdy_q, pop_q, ack_q;

  logic read_elig, skid_eff, occ_full, rx_load, discard;

  // Arbitration, skid register and counter next-state logic
  always_comb begin
    state_d     = state_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    discard     = 1'b0;
    drop_d      = 1'b0;

    read_elig = bus.Host_Rd_Req && (occ_q != '0);
    // A byte arriving into an empty skid is eligible for a grant this cycle
    skid_eff  = skid_vld_q || bus.Rx_Valid;
    occ_full  = (occ_q == OccFull);
    // The WRITE cycle consumes the skid, so it can refill in the same cycle
    rx_load   = bus.Rx_Valid && (!skid_vld_q || (state_q == StWrite));

    unique case (state_q)
      StIdle: begin
        // No grants while the FIFO is still coming out of reset or in BIST
        if (!fifo_rst_q && !bus.BIST_Mode) begin
          // last_wr_q gives an eligible read the grant right after a write
          if (skid_eff && !occ_full && (!last_wr_q || !read_elig)) begin
            state_d = StWrite;
          end else if (read_elig) begin
            state_d = StPop;
          end else if (skid_eff && occ_full) begin
            discard = 1'b1;
          end
        end
      end
      StWrite:   state_d = StIdle;
      StPop:     state_d = StCapture;
      StCapture: state_d = StAck;
      StAck:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    if (discard) begin
      // Exactly one byte is lost: the held one (and a new byte refills the
      // skid) or, with the skid empty, the byte arriving now
      drop_d     = 1'b1;
      skid_vld_d = skid_vld_q && bus.Rx_Valid;
      if (bus.Rx_Valid) begin
        skid_data_d = bus.Rx_Data;
      end
    end else begin
      if (state_q == StWrite) begin
        skid_vld_d = 1'b0;
      end
      if (rx_load) begin
        skid_vld_d  = 1'b1;
        skid_data_d = bus.Rx_Data;
      end
      drop_d = bus.Rx_Valid && !rx_load;
    end
  end

  // Occupancy, drop counter, sync check and read-data capture
  always_comb begin
    occ_d = occ_q;
    if (state_q == StWrite) begin
      occ_d = occ_q + OccOne;
    end else if (state_q == StPop) begin
      occ_d = occ_q - OccOne;
    end

    drop_cnt_d = drop_cnt_q;
    if (drop_d && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    sync_err_d = sync_err_q;
    if ((state_q == StIdle) && !fifo_rst_q && (bus.Fifo_Empty != (occ_q == '0))) begin
      sync_err_d = 1'b1;
    end

    rd_data_d = rd_data_q;
    if (state_q == StCapture) begin
      rd_data_d = bus.Fifo_Data_Out;
    end
  end

  // All state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      occ_q       <= '0;
      drop_cnt_q  <= '0;
      drop_q      <= 1'b0;
      sync_err_q  <= 1'b0;
      fifo_rst_q  <= 1'b1;
      last_wr_q   <= 1'b0;
      rd_data_q   <= '0;
      data_rdy_q  <= 1'b0;
      pop_q       <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      occ_q       <= occ_d;
      drop_cnt_q  <= drop_cnt_d;
      drop_q      <= drop_d;
      sync_err_q  <= sync_err_d;
      fifo_rst_q  <= 1'b0;
      last_wr_q   <= (state_q == StWrite);
      rd_data_q   <= rd_data_d;
      data_rdy_q  <= (state_d == StWrite);
      pop_q       <= (state_d == StPop);
      ack_q       <= (state_d == StAck);
    end
  end

  assign bus.Fifo_Rst      = fifo_rst_q;
  assign bus.Fifo_Wr_Data  = skid_data_q;
  assign bus.Fifo_Data_Rdy = data_rdy_q;
  assign bus.Fifo_Pop_Data = pop_q;
  assign bus.Host_Rd_Ack   = ack_q;
  assign bus.Host_Rd_Data  = rd_data_q;
  assign bus.Occupancy     = occ_q;
  assign bus.Rx_Drop       = drop_q;
  assign bus.Drop_Count    = drop_cnt_q;
  assign bus.Sync_Err      = sync_err_q;

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Directed bench for rx_fifo_ctrl with a small behavioural FIFO attached.
module tb_rx_fifo_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic empty_flip;

  always #5 clk = ~clk;

  rx_fifo_ctrl_if #(.DATA_BITS(8), .FIFO_WIDTH(4)) bus ();

  rx_fifo_ctrl #(.DATA_BITS(8), .FIFO_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural FIFO: registered read data loaded on pop
  logic [7:0] mem [16];
  logic [3:0] wr_ptr, rd_ptr;
  logic [4:0] count;
  logic [7:0] dout;
  logic       fwr, fpop;

  assign fwr  = bus.Fifo_Data_Rdy && (count != 5'd16);
  assign fpop = bus.Fifo_Pop_Data && (count != 5'd0);

  always @(posedge clk) begin
    if (bus.Fifo_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (fwr) begin
        mem[wr_ptr] <= bus.Fifo_Wr_Data;
        wr_ptr      <= wr_ptr + 4'd1;
      end
      if (fpop) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 4'd1;
      end
      if (fwr && !fpop) count <= count + 5'd1;
      else if (!fwr && fpop) count <= count - 5'd1;
    end
  end

  assign bus.Fifo_Empty    = (count == 5'd0) ^ empty_flip;
  assign bus.Fifo_Data_Out = dout;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.Rx_Valid    = 1'b0;
    bus.Rx_Data     = '0;
    bus.Host_Rd_Req = 1'b0;
    bus.BIST_Mode   = 1'b0;
    empty_flip      = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus.Rx_Valid = 1'b1;
    bus.Rx_Data  = d;
    tick();
    bus.Rx_Valid = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] d;

    // Reset values
    rst = 1'b0;
    bus.Rx_Valid    = 1'b0;
    bus.Rx_Data     = '0;
    bus.Host_Rd_Req = 1'b0;
    bus.BIST_Mode   = 1'b0;
    empty_flip      = 1'b0;
    tick();
    tick();
    check("rst_fifo_rst", 32'(bus.Fifo_Rst), 1);
    check("rst_occ", 32'(bus.Occupancy), 0);
    check("rst_dropcnt", 32'(bus.Drop_Count), 0);
    check("rst_syncerr", 32'(bus.Sync_Err), 0);
    check("rst_strobes", {28'd0, bus.Fifo_Data_Rdy, bus.Fifo_Pop_Data, bus.Host_Rd_Ack,
                          bus.Rx_Drop}, 0);
    check("rst_rddata", 32'(bus.Host_Rd_Data), 0);
    check("rst_wrdata", 32'(bus.Fifo_Wr_Data), 0);
    #2 rst = 1'b1;
    #1 check("rel_fifo_rst_held", 32'(bus.Fifo_Rst), 1);
    tick();
    check("rel_fifo_rst_drop", 32'(bus.Fifo_Rst), 0);
    check("rel_no_strobe", 32'(bus.Fifo_Data_Rdy), 0);

    // Single write
    bus.Rx_Valid = 1'b1;
    bus.Rx_Data  = 8'hA5;
    tick();
    bus.Rx_Valid = 1'b0;
    check("w1_rdy", 32'(bus.Fifo_Data_Rdy), 1);
    check("w1_data", 32'(bus.Fifo_Wr_Data), 32'hA5);
    tick();
    check("w1_rdy_low", 32'(bus.Fifo_Data_Rdy), 0);
    check("w1_occ", 32'(bus.Occupancy), 1);

    // Read on empty waits, then write/read ordering
    do_reset();
    bus.Host_Rd_Req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("empty_no_pop", {30'd0, bus.Fifo_Pop_Data, bus.Host_Rd_Ack}, 0);
    end
    bus.Host_Rd_Req = 1'b0;
    tick();
    write_byte(8'h11);
    write_byte(8'h22);
    check("wr_occ2", 32'(bus.Occupancy), 2);
    bus.Host_Rd_Req = 1'b1;
    tick();
    check("rd1_pop", 32'(bus.Fifo_Pop_Data), 1);
    tick();
    check("rd1_cap_noack", 32'(bus.Host_Rd_Ack), 0);
    check("rd1_occ", 32'(bus.Occupancy), 1);
    tick();
    check("rd1_ack", 32'(bus.Host_Rd_Ack), 1);
    check("rd1_data", 32'(bus.Host_Rd_Data), 32'h11);
    tick();
    check("rd1_ack_pulse", 32'(bus.Host_Rd_Ack), 0);
    tick();
    tick();
    tick();
    check("rd2_ack", 32'(bus.Host_Rd_Ack), 1);
    check("rd2_data", 32'(bus.Host_Rd_Data), 32'h22);
    check("rd2_occ", 32'(bus.Occupancy), 0);
    bus.Host_Rd_Req = 1'b0;
    tick();
    tick();
    check("rd_no_extra_pop", 32'(bus.Fifo_Pop_Data), 0);

    // Full FIFO drop
    do_reset();
    for (int i = 0; i < 16; i++) begin
      d = 8'h10 + 8'(i);
      write_byte(d);
    end
    check("full_occ", 32'(bus.Occupancy), 16);
    bus.Rx_Valid = 1'b1;
    bus.Rx_Data  = 8'hEE;
    tick();
    bus.Rx_Valid = 1'b0;
    check("full_drop_pulse", 32'(bus.Rx_Drop), 1);
    check("full_no_write", 32'(bus.Fifo_Data_Rdy), 0);
    tick();
    check("full_drop_low", 32'(bus.Rx_Drop), 0);
    check("full_dropcnt", 32'(bus.Drop_Count), 1);
    check("full_occ_held", 32'(bus.Occupancy), 16);
    bus.Host_Rd_Req = 1'b1;
    tick();
    tick();
    tick();
    bus.Host_Rd_Req = 1'b0;
    check("full_rd_data", 32'(bus.Host_Rd_Data), 32'h10);
    tick();
    check("full_occ_after_rd", 32'(bus.Occupancy), 15);
    check("full_syncerr", 32'(bus.Sync_Err), 0);

    // Simultaneous write and read, fairness and skid during POP
    do_reset();
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    tick();
    bus.Rx_Valid    = 1'b1;
    bus.Rx_Data     = 8'h44;
    bus.Host_Rd_Req = 1'b1;
    tick();
    bus.Rx_Valid = 1'b0;
    check("sim_write_first", {30'd0, bus.Fifo_Data_Rdy, bus.Fifo_Pop_Data}, 2);
    check("sim_wr_data", 32'(bus.Fifo_Wr_Data), 32'h44);
    tick();
    check("sim_occ4", 32'(bus.Occupancy), 4);
    tick();
    check("sim_pop", {30'd0, bus.Fifo_Data_Rdy, bus.Fifo_Pop_Data}, 1);
    bus.Rx_Valid = 1'b1;
    bus.Rx_Data  = 8'h55;
    tick();
    bus.Rx_Valid = 1'b0;
    check("sim_no_drop", 32'(bus.Rx_Drop), 0);
    tick();
    check("sim_ack", 32'(bus.Host_Rd_Ack), 1);
    check("sim_rd_data", 32'(bus.Host_Rd_Data), 32'h01);
    bus.Host_Rd_Req = 1'b0;
    tick();
    check("sim_idle_gap", 32'(bus.Fifo_Data_Rdy), 0);
    tick();
    check("sim_skid_write", 32'(bus.Fifo_Data_Rdy), 1);
    check("sim_skid_data", 32'(bus.Fifo_Wr_Data), 32'h55);
    tick();
    check("sim_occ_end", 32'(bus.Occupancy), 4);
    check("sim_dropcnt", 32'(bus.Drop_Count), 0);

    // BIST holds one byte, drops the next; read waits for the write
    do_reset();
    bus.BIST_Mode = 1'b1;
    bus.Rx_Valid  = 1'b1;
    bus.Rx_Data   = 8'h77;
    tick();
    check("bist_no_write", 32'(bus.Fifo_Data_Rdy), 0);
    check("bist_first_kept", 32'(bus.Rx_Drop), 0);
    bus.Rx_Data = 8'h88;
    tick();
    bus.Rx_Valid    = 1'b0;
    bus.Host_Rd_Req = 1'b1;
    check("bist_second_drop", 32'(bus.Rx_Drop), 1);
    tick();
    check("bist_dropcnt", 32'(bus.Drop_Count), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bist_quiet", {29'd0, bus.Fifo_Data_Rdy, bus.Fifo_Pop_Data, bus.Host_Rd_Ack}, 0);
    end
    bus.BIST_Mode = 1'b0;
    tick();
    check("bist_exit_write", 32'(bus.Fifo_Data_Rdy), 1);
    check("bist_exit_data", 32'(bus.Fifo_Wr_Data), 32'h77);
    tick();
    check("bist_occ1", 32'(bus.Occupancy), 1);
    check("bist_still_noack", 32'(bus.Host_Rd_Ack), 0);
    tick();
    tick();
    tick();
    check("bist_ack", 32'(bus.Host_Rd_Ack), 1);
    check("bist_rd_data", 32'(bus.Host_Rd_Data), 32'h77);
    bus.Host_Rd_Req = 1'b0;
    tick();

    // Consistency flag is sticky
    empty_flip = 1'b1;
    tick();
    empty_flip = 1'b0;
    check("sync_set", 32'(bus.Sync_Err), 1);
    tick();
    check("sync_sticky", 32'(bus.Sync_Err), 1);

    // Reset during CAPTURE
    do_reset();
    write_byte(8'h99);
    bus.Host_Rd_Req = 1'b1;
    tick();
    check("mid_pop", 32'(bus.Fifo_Pop_Data), 1);
    bus.Host_Rd_Req = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    check("mid_fifo_rst", 32'(bus.Fifo_Rst), 1);
    check("mid_occ", 32'(bus.Occupancy), 0);
    check("mid_rddata", 32'(bus.Host_Rd_Data), 0);
    check("mid_syncerr", 32'(bus.Sync_Err), 0);
    tick();
    check("mid_no_ack", 32'(bus.Host_Rd_Ack), 0);
    #2 rst = 1'b1;
    #1 check("mid_rst_held", 32'(bus.Fifo_Rst), 1);
    tick();
    check("mid_rst_rel", 32'(bus.Fifo_Rst), 0);
    check("mid_quiet", {29'd0, bus.Fifo_Data_Rdy, bus.Fifo_Pop_Data, bus.Host_Rd_Ack}, 0);
    tick();
    check("mid_no_late_ack", 32'(bus.Host_Rd_Ack), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
